// File: rtl/npc_seq_ctrl.sv
// npc_seq_ctrl: multi-cycle sequencer for the NPC core.
// Owns PC and IR, drives the imem/dmem handshakes, gates register-file
// writes to a single WB cycle per instruction, halts on ebreak and traps
// into an error state when a handshake stalls for too long.
module npc_seq_ctrl #(
  parameter logic [63:0] PC_RESET    = 64'h0000_0000_8000_0000,
  parameter int          TO_W        = 8,
  parameter int          MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  input  logic        dmem_done,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_ebreak,
  input  logic        rf_wen_in,
  input  logic [63:0] next_pc,
  output logic [63:0] pc,
  output logic [31:0] inst,
  output logic        rf_wen,
  output logic        halted,
  output logic        timeout_err,
  output logic [63:0] mcycle,
  output logic [63:0] minstret,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IF_REQ  = 3'd0,
    S_IF_WAIT = 3'd1,
    S_EX      = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5,
    S_ERR     = 3'd6
  } state_e;

  localparam logic [31:0]     NOP_INST    = 32'h0000_0013;
  localparam logic [TO_W-1:0] TIMEOUT_LIM = TO_W'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [63:0]      mcycle_q, mcycle_d;
  logic [63:0]      minstret_q, minstret_d;
  logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             imem_req_q, imem_req_d;
  logic             dmem_req_q, dmem_req_d;
  logic             wb_q, wb_d;
  logic             halted_q, halted_d;
  logic             timeout_err_q, timeout_err_d;
  logic             waiting;

  // Next-state, architectural updates, wait counter and the next-cycle
  // values of the state-decoded outputs (registered so they are glitch free).
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    minstret_d = minstret_q;
    waiting    = 1'b0;

    case (state_q)
      S_IF_REQ: begin
        if (imem_gnt) state_d = S_IF_WAIT;
        else          waiting = 1'b1;
      end
      S_IF_WAIT: begin
        if (imem_rvalid) begin
          inst_d  = imem_rdata;
          state_d = S_EX;
        end else begin
          waiting = 1'b1;
        end
      end
      S_EX: begin
        if (is_ebreak) begin
          minstret_d = minstret_q + 64'd1;
          state_d    = S_HALT;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_done) state_d = S_WB;
        else           waiting = 1'b1;
      end
      S_WB: begin
        pc_d       = next_pc;
        minstret_d = minstret_q + 64'd1;
        state_d    = S_IF_REQ;
      end
      S_HALT:  state_d = S_HALT;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase

    if (waiting && (wait_cnt_q == TIMEOUT_LIM)) state_d = S_ERR;

    if (state_d != state_q) wait_cnt_d = '0;
    else if (waiting)       wait_cnt_d = wait_cnt_q + TO_W'(1);
    else                    wait_cnt_d = wait_cnt_q;

    if ((state_q == S_HALT) || (state_q == S_ERR)) mcycle_d = mcycle_q;
    else                                           mcycle_d = mcycle_q + 64'd1;

    imem_req_d    = (state_d == S_IF_REQ);
    dmem_req_d    = (state_d == S_MEM);
    wb_d          = (state_d == S_WB);
    halted_d      = (state_d == S_HALT);
    timeout_err_d = (state_d == S_ERR);
  end

  // All sequencer state; reset returns immediately to the fetch-from-reset-PC point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IF_REQ;
      pc_q          <= PC_RESET;
      inst_q        <= NOP_INST;
      mcycle_q      <= 64'd0;
      minstret_q    <= 64'd0;
      wait_cnt_q    <= '0;
      imem_req_q    <= 1'b1;
      dmem_req_q    <= 1'b0;
      wb_q          <= 1'b0;
      halted_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      mcycle_q      <= mcycle_d;
      minstret_q    <= minstret_d;
      wait_cnt_q    <= wait_cnt_d;
      imem_req_q    <= imem_req_d;
      dmem_req_q    <= dmem_req_d;
      wb_q          <= wb_d;
      halted_q      <= halted_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // The datapath write enable only reaches the register file during WB.
  assign rf_wen      = wb_q & rf_wen_in;
  assign imem_req    = imem_req_q;
  assign dmem_req    = dmem_req_q;
  assign halted      = halted_q;
  assign timeout_err = timeout_err_q;
  assign pc          = pc_q;
  assign inst        = inst_q;
  assign mcycle      = mcycle_q;
  assign minstret    = minstret_q;
  assign state       = state_q;

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// tb_npc_seq_ctrl: table-driven bench for the sequencer. Each record holds the
// inputs for one cycle and the outputs expected during that cycle.
module tb_npc_seq_ctrl;

  localparam logic [63:0] P = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_done;
  logic        is_load, is_store, is_ebreak, rf_wen_in;
  logic [63:0] next_pc;
  logic [63:0] pc;
  logic [31:0] inst;
  logic        rf_wen, halted, timeout_err;
  logic [63:0] mcycle, minstret;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          rst_before;
    bit          mid_rst;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        ld, sto, eb, wen_in;
    logic [63:0] npc;
    logic [2:0]  e_st;
    logic        e_ireq, e_dreq, e_wen, e_hlt, e_terr;
    logic [63:0] e_pc, e_minst, e_mcyc;
  } vec_t;

  vec_t vecs[$];

  npc_seq_ctrl #(
    .PC_RESET   (P),
    .TO_W       (8),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_done  (dmem_done),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_ebreak  (is_ebreak),
    .rf_wen_in  (rf_wen_in),
    .next_pc    (next_pc),
    .pc         (pc),
    .inst       (inst),
    .rf_wen     (rf_wen),
    .halted     (halted),
    .timeout_err(timeout_err),
    .mcycle     (mcycle),
    .minstret   (minstret),
    .state      (state)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  function automatic vec_t mk(bit rb, bit mr, logic gnt, logic rv, logic [31:0] rdata,
                              logic ld, logic sto, logic eb, logic wen_in, logic [63:0] npc,
                              logic [2:0] e_st, logic e_ireq, logic e_dreq, logic e_wen,
                              logic e_hlt, logic e_terr, logic [63:0] e_pc,
                              logic [63:0] e_minst, logic [63:0] e_mcyc);
    vec_t v;
    v.rst_before = rb; v.mid_rst = mr;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata;
    v.ld = ld; v.sto = sto; v.eb = eb; v.wen_in = wen_in; v.npc = npc;
    v.e_st = e_st; v.e_ireq = e_ireq; v.e_dreq = e_dreq; v.e_wen = e_wen;
    v.e_hlt = e_hlt; v.e_terr = e_terr; v.e_pc = e_pc;
    v.e_minst = e_minst; v.e_mcyc = e_mcyc;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    imem_gnt    = v.gnt;
    imem_rvalid = v.rv;
    imem_rdata  = v.rdata;
    is_load     = v.ld;
    is_store    = v.sto;
    is_ebreak   = v.eb;
    rf_wen_in   = v.wen_in;
    next_pc     = v.npc;
    dmem_done   = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Holds reset across two edges, then releases it well away from an edge;
  // the caller resumes in cycle 1 (IF_REQ).
  task automatic doReset();
    rst = 1'b1;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; dmem_done = 0;
    is_load = 0; is_store = 0; is_ebreak = 0; rf_wen_in = 0; next_pc = '0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    // Three back-to-back ALU instructions with ideal memory; rf_wen_in held
    // high throughout so only WB may let it through.
    for (int k = 0; k < 3; k++) begin
      logic [63:0] cur, nxt;
      int b;
      cur = P + 64'(4 * k);
      nxt = P + 64'(4 * (k + 1));
      b   = 4 * k + 1;
      vecs.push_back(mk(k == 0, 0, 1, 0, 32'h0, 0, 0, 0, 1, nxt, 3'd0, 1, 0, 0, 0, 0, cur, 64'(k), 64'(b - 1)));
      vecs.push_back(mk(0, 0, 0, 1, 32'h00100093, 0, 0, 0, 1, nxt, 3'd1, 0, 0, 0, 0, 0, cur, 64'(k), 64'(b)));
      vecs.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 1, nxt, 3'd2, 0, 0, 0, 0, 0, cur, 64'(k), 64'(b + 1)));
      vecs.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 1, nxt, 3'd4, 0, 0, 1, 0, 0, cur, 64'(k), 64'(b + 2)));
    end
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, '0, 3'd0, 1, 0, 0, 0, 0, P + 64'd12, 64'd3, 64'd12));

    // ebreak (also flagged as load to exercise priority) halts after EX.
    vecs.push_back(mk(1, 0, 1, 0, 32'h0, 0, 0, 0, 1, P + 64'd4, 3'd0, 1, 0, 0, 0, 0, P, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h00100073, 0, 0, 0, 1, P + 64'd4, 3'd1, 0, 0, 0, 0, 0, P, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 1, 0, 1, 1, P + 64'd4, 3'd2, 0, 0, 0, 0, 0, P, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 1, 1, P + 64'd4, 3'd5, 0, 0, 0, 1, 0, P, 1, 3));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0, 0, 0, 0, 1, P + 64'd4, 3'd5, 0, 0, 0, 1, 0, P, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 1, P + 64'd4, 3'd5, 0, 0, 0, 1, 0, P, 1, 3));

    // imem_gnt never arrives: five IF_REQ cycles, then sticky ERR.
    for (int n = 1; n <= 5; n++)
      vecs.push_back(mk(n == 1, 0, 0, 0, 32'h0, 0, 0, 0, 0, '0, 3'd0, 1, 0, 0, 0, 0, P, 0, 64'(n - 1)));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, '0, 3'd6, 0, 0, 0, 0, 1, P, 0, 5));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0, 0, 0, 0, 0, '0, 3'd6, 0, 0, 0, 0, 1, P, 0, 5));

    // imem_gnt arrives exactly in the limit cycle: normal transition wins.
    for (int n = 1; n <= 4; n++)
      vecs.push_back(mk(n == 1, 0, 0, 0, 32'h0, 0, 0, 0, 0, '0, 3'd0, 1, 0, 0, 0, 0, P, 0, 64'(n - 1)));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0, 0, 0, 0, 0, '0, 3'd0, 1, 0, 0, 0, 0, P, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, '0, 3'd1, 0, 0, 0, 0, 0, P, 0, 5));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, '0, 3'd1, 0, 0, 0, 0, 0, P, 0, 6));

    // Store reaches MEM, then reset is asserted mid-cycle.
    vecs.push_back(mk(1, 0, 1, 0, 32'h0, 0, 0, 0, 1, P + 64'd4, 3'd0, 1, 0, 0, 0, 0, P, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h00112023, 0, 0, 0, 1, P + 64'd4, 3'd1, 0, 0, 0, 0, 0, P, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 0, 1, 0, 1, P + 64'd4, 3'd2, 0, 0, 0, 0, 0, P, 0, 2));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0, 0, 1, 0, 1, P + 64'd4, 3'd3, 0, 1, 0, 0, 0, P, 0, 3));

    // Load with dmem_done low for three MEM cycles (done driven by hand below).
    vecs.push_back(mk(1, 0, 1, 0, 32'h0, 0, 0, 0, 1, P + 64'd4, 3'd0, 1, 0, 0, 0, 0, P, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h00002103, 0, 0, 0, 1, P + 64'd4, 3'd1, 0, 0, 0, 0, 0, P, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 1, 0, 0, 1, P + 64'd4, 3'd2, 0, 0, 0, 0, 0, P, 0, 2));
    for (int n = 4; n <= 7; n++)
      vecs.push_back(mk(0, 0, 0, 0, 32'h0, 1, 0, 0, 1, P + 64'd4, 3'd3, 0, 1, 0, 0, 0, P, 0, 64'(n - 1)));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 1, 0, 0, 1, P + 64'd4, 3'd4, 0, 0, 1, 0, 0, P, 0, 7));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0, 0, 0, 0, 1, P + 64'd4, 3'd0, 1, 0, 0, 0, 0, P + 64'd4, 1, 8));

    // Apply every record: drive inputs, check outputs mid-cycle, advance one edge.
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_before) doReset();
      applyStimulus(vecs[i]);
      // Load segment: dmem_done only in the fourth MEM cycle (mcycle 6).
      if (vecs[i].ld && vecs[i].e_st == 3'd3 && vecs[i].e_mcyc == 64'd6) dmem_done = 1'b1;
      #1;
      checkOutput($sformatf("r%0d_state", i),    64'(state),       64'(vecs[i].e_st));
      checkOutput($sformatf("r%0d_imem_req", i), 64'(imem_req),    64'(vecs[i].e_ireq));
      checkOutput($sformatf("r%0d_dmem_req", i), 64'(dmem_req),    64'(vecs[i].e_dreq));
      checkOutput($sformatf("r%0d_rf_wen", i),   64'(rf_wen),      64'(vecs[i].e_wen));
      checkOutput($sformatf("r%0d_halted", i),   64'(halted),      64'(vecs[i].e_hlt));
      checkOutput($sformatf("r%0d_timeout", i),  64'(timeout_err), 64'(vecs[i].e_terr));
      checkOutput($sformatf("r%0d_pc", i),       pc,               vecs[i].e_pc);
      checkOutput($sformatf("r%0d_minstret", i), minstret,         vecs[i].e_minst);
      checkOutput($sformatf("r%0d_mcycle", i),   mcycle,           vecs[i].e_mcyc);
      if (vecs[i].mid_rst) begin
        // Reset must take effect without waiting for a clock edge.
        rst = 1'b1;
        #1;
        checkOutput("midrst_dmem_req", 64'(dmem_req), 64'd0);
        checkOutput("midrst_state",    64'(state),    64'd0);
        checkOutput("midrst_pc",       pc,            P);
        checkOutput("midrst_mcycle",   mcycle,        64'd0);
        checkOutput("midrst_minstret", minstret,      64'd0);
        checkOutput("midrst_rf_wen",   64'(rf_wen),   64'd0);
        checkOutput("midrst_inst",     64'(inst),     64'h13);
      end
      @(posedge clk);
      #2;
    end

    $display("[TB] applied %0d vectors", vecs.size());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/npc_seq_ctrl.md
Name: npc_seq_ctrl

Overview:
- Multi-cycle sequencer for the NPC core.
- Owns the PC and instruction register (IR).
- Drives the instruction-memory and data-memory request handshakes.
- Gates register-file writes so each instruction commits exactly once.
- Halts on ebreak and flags a memory-handshake timeout.
- Sits between the fetch/decode/execute datapath and the memory interfaces, replacing free-running per-clock PC update.

Parameters:
PC_RESET, 64'h0000_0000_8000_0000, PC value loaded on reset
TO_W, 8, width of wait-cycle counter
MEM_TIMEOUT, 255, max cycles spent in any single wait state before error (must fit in TO_W)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
imem_req  out  1  instruction fetch request, address = pc
imem_gnt  in  1  fetch request accepted
imem_rvalid  in  1  fetch data valid
imem_rdata  in  32  fetched instruction
dmem_req  out  1  data access request (load/store from datapath)
dmem_done  in  1  data access complete
is_load  in  1  decoded instruction is a load
is_store  in  1  decoded instruction is a store
is_ebreak  in  1  decoded instruction is ebreak
rf_wen_in  in  1  datapath register write enable
next_pc  in  64  PC of next instruction, from execute
pc  out  64  current PC
inst  out  32  instruction register
rf_wen  out  1  gated register-file write enable
halted  out  1  ebreak reached
timeout_err  out  1  handshake timeout, sticky
mcycle  out  64  cycle counter
minstret  out  64  retired-instruction counter
state  out  3  current FSM state, for debug/trace

Behaviour:
- Reset (async, rst=1):
  - state=IF_REQ, pc=PC_RESET, inst=32'h0000_0013 (nop).
  - mcycle=0, minstret=0, wait counter=0.
  - halted=0, timeout_err=0, rf_wen=0, dmem_req=0.
  - imem_req=1 once rst deasserts.
- State encoding: IF_REQ=0, IF_WAIT=1, EX=2, MEM=3, WB=4, HALT=5, ERR=6. Value 7 is illegal and goes to ERR.
- IF_REQ: imem_req=1. On imem_gnt go to IF_WAIT. imem_rvalid is ignored in this state.
- IF_WAIT: imem_req=0. On imem_rvalid, inst<=imem_rdata and go to EX.
- EX: one cycle for the combinational decode/execute path to settle.
  - is_ebreak has priority: go to HALT, minstret++, no register write.
  - Else is_load|is_store: go to MEM.
  - Else: go to WB.
- MEM: dmem_req=1 for every cycle in MEM. On dmem_done go to WB; dmem_req drops in the following cycle.
- WB: single cycle.
  - rf_wen=rf_wen_in.
  - pc<=next_pc, minstret++.
  - Go to IF_REQ.
- rf_wen is 0 in every state other than WB.
- HALT: halted=1. Absorbing until reset; all requests 0.
- ERR: timeout_err=1. Absorbing until reset; all requests 0.
- Wait counter:
  - Cleared on every state change.
  - Increments each cycle spent in IF_REQ, IF_WAIT or MEM without the exit condition.
  - If it reaches MEM_TIMEOUT with the exit condition still absent, go to ERR next cycle.
  - An exit condition arriving in the same cycle the counter hits the limit wins (normal transition).
- mcycle: increments every cycle the state is not HALT/ERR. Wraps mod 2^64; minstret likewise.
- Latency: with gnt in the first IF_REQ cycle and rvalid in the first IF_WAIT cycle:
  - non-memory instruction: 4 cycles;
  - memory instruction with dmem_done in the first MEM cycle: 5 cycles.
- pc changes only in WB; inst changes only on IF_WAIT & imem_rvalid. Both are stable through EX/MEM/WB.
- next_pc is sampled only in WB. Misaligned next_pc is passed through unchanged; alignment checks live elsewhere.
- Reset mid-operation (any state, including MEM with dmem_req=1): immediate return to reset values. No partial commit — rf_wen=0, minstret unchanged from reset value 0.

Test Plan:
- Reset release, imem_gnt=1 immediately, rvalid one cycle later with 32'h00100093 (addi x1,x0,1), rf_wen_in=1, next_pc=0x80000004 -> rf_wen=1 exactly in cycle 4; pc=0x80000004 and minstret=1 in cycle 5; imem_req re-asserted.
- Load instruction, dmem_done held low 3 MEM cycles -> dmem_req=1 for 4 cycles; rf_wen pulses once after done; total latency 8 cycles; minstret=1.
- ebreak fetched (32'h00100073, is_ebreak=1) -> HALT after EX; halted=1; rf_wen never asserted; minstret=1; mcycle frozen; no further imem_req.
- imem_gnt held low with MEM_TIMEOUT=4 -> ERR; timeout_err=1 sticky; imem_req=0 thereafter. Separately, gnt arriving in the exact limit cycle -> IF_WAIT, no error.
- rst asserted during MEM with dmem_req=1 -> dmem_req=0 and state=IF_REQ without waiting for a clock edge; pc=0x80000000; counters=0; no rf_wen pulse.
- Back-to-back 3 ALU instructions with ideal memory -> rf_wen pulses at cycles 4, 8, 12; minstret=3; mcycle=12 at end of cycle 12.
